// File: rtl/cache_mem_arbiter.sv
// Shares one downstream read/write port between the I-cache and D-cache.
// Reads are round-robin arbitrated; D-cache write-backs go through a one-line buffer.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 128,
    parameter int OFS_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ic_rd_req,
    input  logic [2:0]        ic_rd_type,
    input  logic [ADDR_W-1:0] ic_rd_addr,
    output logic              ic_rd_rdy,
    output logic              ic_ret_valid,
    output logic              ic_ret_last,

    input  logic              dc_rd_req,
    input  logic [2:0]        dc_rd_type,
    input  logic [ADDR_W-1:0] dc_rd_addr,
    output logic              dc_rd_rdy,
    output logic              dc_ret_valid,
    output logic              dc_ret_last,

    output logic [DATA_W-1:0] ret_data,

    input  logic              dc_wr_req,
    input  logic [2:0]        dc_wr_type,
    input  logic [ADDR_W-1:0] dc_wr_addr,
    input  logic [3:0]        dc_wr_wstrb,
    input  logic [LINE_W-1:0] dc_wr_data,
    output logic              dc_wr_rdy,

    output logic              mem_rd_req,
    output logic [2:0]        mem_rd_type,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_rdy,
    input  logic              mem_ret_valid,
    input  logic              mem_ret_last,
    input  logic [DATA_W-1:0] mem_ret_data,

    output logic              mem_wr_req,
    output logic [2:0]        mem_wr_type,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [3:0]        mem_wr_wstrb,
    output logic [LINE_W-1:0] mem_wr_data,
    input  logic              mem_wr_rdy
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_BUSY = 1'b1
    } wr_state_t;

    rd_state_t rd_state;
    rd_state_t rd_next;
    wr_state_t wr_state;
    wr_state_t wr_next;

    logic              gnt_dc;
    logic              rr_dc;
    logic              grant_valid;
    logic              grant_dc;

    logic [ADDR_W-1:0] wbuf_addr;
    logic [2:0]        wbuf_type;
    logic [3:0]        wbuf_wstrb;
    logic [LINE_W-1:0] wbuf_data;

    logic              wr_accept;
    logic              ic_hazard;
    logic              dc_hazard;
    logic              ic_elig;
    logic              dc_elig;

    assign wr_accept = (wr_state == W_IDLE) && dc_wr_req;

    // A line being accepted into the buffer this cycle blocks a same-line read just like a buffered one.
    always_comb begin
        ic_hazard = 1'b0;
        dc_hazard = 1'b0;
        if (wr_state == W_BUSY) begin
            if (ic_rd_addr[ADDR_W-1:OFS_W] == wbuf_addr[ADDR_W-1:OFS_W])
                ic_hazard = 1'b1;
            if (dc_rd_addr[ADDR_W-1:OFS_W] == wbuf_addr[ADDR_W-1:OFS_W])
                dc_hazard = 1'b1;
        end
        if (wr_accept) begin
            if (ic_rd_addr[ADDR_W-1:OFS_W] == dc_wr_addr[ADDR_W-1:OFS_W])
                ic_hazard = 1'b1;
            if (dc_rd_addr[ADDR_W-1:OFS_W] == dc_wr_addr[ADDR_W-1:OFS_W])
                dc_hazard = 1'b1;
        end
    end

    assign ic_elig = ic_rd_req && !ic_hazard;
    assign dc_elig = dc_rd_req && !dc_hazard;

    always_comb begin
        grant_valid = 1'b0;
        grant_dc    = 1'b0;
        if (rd_state == R_IDLE) begin
            if (ic_elig && dc_elig) begin
                grant_valid = 1'b1;
                grant_dc    = rr_dc;
            end else if (dc_elig) begin
                grant_valid = 1'b1;
                grant_dc    = 1'b1;
            end else if (ic_elig) begin
                grant_valid = 1'b1;
                grant_dc    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_state <= R_IDLE;
        else
            rd_state <= rd_next;
    end

    always_comb begin
        rd_next      = rd_state;
        mem_rd_req   = 1'b0;
        ic_rd_rdy    = 1'b0;
        dc_rd_rdy    = 1'b0;
        ic_ret_valid = 1'b0;
        ic_ret_last  = 1'b0;
        dc_ret_valid = 1'b0;
        dc_ret_last  = 1'b0;
        ret_data     = '0;
        case (rd_state)
            R_IDLE: begin
                if (grant_valid)
                    rd_next = R_REQ;
            end
            R_REQ: begin
                mem_rd_req = 1'b1;
                if (mem_rd_rdy) begin
                    ic_rd_rdy = !gnt_dc;
                    dc_rd_rdy = gnt_dc;
                    rd_next   = R_RESP;
                end
            end
            R_RESP: begin
                ret_data     = mem_ret_data;
                ic_ret_valid = mem_ret_valid && !gnt_dc;
                ic_ret_last  = mem_ret_valid && mem_ret_last && !gnt_dc;
                dc_ret_valid = mem_ret_valid && gnt_dc;
                dc_ret_last  = mem_ret_valid && mem_ret_last && gnt_dc;
                if (mem_ret_valid && mem_ret_last)
                    rd_next = R_IDLE;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    // After any grant the other client gets priority on the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_dc      <= 1'b0;
            rr_dc       <= 1'b1;
            mem_rd_type <= '0;
            mem_rd_addr <= '0;
        end else if (grant_valid) begin
            gnt_dc      <= grant_dc;
            rr_dc       <= !grant_dc;
            mem_rd_type <= grant_dc ? dc_rd_type : ic_rd_type;
            mem_rd_addr <= grant_dc ? dc_rd_addr : ic_rd_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wr_state <= W_IDLE;
        else
            wr_state <= wr_next;
    end

    always_comb begin
        wr_next    = wr_state;
        dc_wr_rdy  = 1'b0;
        mem_wr_req = 1'b0;
        case (wr_state)
            W_IDLE: begin
                dc_wr_rdy = 1'b1;
                if (dc_wr_req)
                    wr_next = W_BUSY;
            end
            W_BUSY: begin
                mem_wr_req = 1'b1;
                if (mem_wr_rdy)
                    wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbuf_addr  <= '0;
            wbuf_type  <= '0;
            wbuf_wstrb <= '0;
            wbuf_data  <= '0;
        end else if (wr_accept) begin
            wbuf_addr  <= dc_wr_addr;
            wbuf_type  <= dc_wr_type;
            wbuf_wstrb <= dc_wr_wstrb;
            wbuf_data  <= dc_wr_data;
        end
    end

    assign mem_wr_type  = wbuf_type;
    assign mem_wr_addr  = wbuf_addr;
    assign mem_wr_wstrb = wbuf_wstrb;
    assign mem_wr_data  = wbuf_data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter; the bench plays the downstream memory and
// scoreboards every returned beat against the client it was meant for.
`define CHK(tag, obs, exp) checkOutput(tag, 128'(obs), 128'(exp))

module tb_cache_mem_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ic_rd_req;
   logic [2:0]   ic_rd_type;
   logic [31:0]  ic_rd_addr;
   logic         ic_rd_rdy;
   logic         ic_ret_valid;
   logic         ic_ret_last;
   logic         dc_rd_req;
   logic [2:0]   dc_rd_type;
   logic [31:0]  dc_rd_addr;
   logic         dc_rd_rdy;
   logic         dc_ret_valid;
   logic         dc_ret_last;
   logic [31:0]  ret_data;
   logic         dc_wr_req;
   logic [2:0]   dc_wr_type;
   logic [31:0]  dc_wr_addr;
   logic [3:0]   dc_wr_wstrb;
   logic [127:0] dc_wr_data;
   logic         dc_wr_rdy;
   logic         mem_rd_req;
   logic [2:0]   mem_rd_type;
   logic [31:0]  mem_rd_addr;
   logic         mem_rd_rdy;
   logic         mem_ret_valid;
   logic         mem_ret_last;
   logic [31:0]  mem_ret_data;
   logic         mem_wr_req;
   logic [2:0]   mem_wr_type;
   logic [31:0]  mem_wr_addr;
   logic [3:0]   mem_wr_wstrb;
   logic [127:0] mem_wr_data;
   logic         mem_wr_rdy;

   cache_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .LINE_W(128), .OFS_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
      .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
      .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
      .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
      .ret_data(ret_data),
      .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
      .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
      .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr),
      .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last),
      .mem_ret_data(mem_ret_data),
      .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type), .mem_wr_addr(mem_wr_addr),
      .mem_wr_wstrb(mem_wr_wstrb), .mem_wr_data(mem_wr_data), .mem_wr_rdy(mem_wr_rdy)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   typedef struct {
      logic        to_dc;
      logic [31:0] data;
      logic        last;
   } beat_t;

   beat_t sb[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   localparam logic [127:0] WR_LINE = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32A5;

   // Compares an observed value against the expected one and records the outcome.
   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Records the outcome of a comparison evaluated by the caller.
   task automatic checkMatch(input string tag, input bit ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $error("[TB] FAIL %s", tag);
      end
   endtask

   // Advances to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives both read clients' request inputs.
   task automatic applyStimulus(input logic ic_req, input logic [2:0] ic_type, input logic [31:0] ic_addr,
                                input logic dc_req, input logic [2:0] dc_type, input logic [31:0] dc_addr);
      ic_rd_req  = ic_req;
      ic_rd_type = ic_type;
      ic_rd_addr = ic_addr;
      dc_rd_req  = dc_req;
      dc_rd_type = dc_type;
      dc_rd_addr = dc_addr;
   endtask

   // Checks that every output sits at its reset value.
   task automatic checkIdleOutputs(input string tag);
      `CHK({tag, "_flags"}, {ic_rd_rdy, ic_ret_valid, ic_ret_last, dc_rd_rdy, dc_ret_valid,
                             dc_ret_last, mem_rd_req, mem_wr_req, dc_wr_rdy}, 9'b0_0000_0001);
      `CHK({tag, "_fields"}, {ret_data, mem_rd_addr, mem_rd_type, mem_wr_type, mem_wr_addr, mem_wr_wstrb}, 0);
      `CHK({tag, "_wdata"}, mem_wr_data, 0);
   endtask

   // Applies reset with all inputs quiet, then releases it.
   task automatic resetDut();
      rst_n = 1'b0;
      applyStimulus(1'b0, 3'b000, 32'h0, 1'b0, 3'b000, 32'h0);
      dc_wr_req = 1'b0; dc_wr_type = 3'b000; dc_wr_addr = 32'h0; dc_wr_wstrb = 4'h0; dc_wr_data = '0;
      mem_rd_rdy = 1'b0; mem_ret_valid = 1'b0; mem_ret_last = 1'b0; mem_ret_data = 32'h0;
      mem_wr_rdy = 1'b0;
      tick();
      tick();
      checkIdleOutputs("reset");
      rst_n = 1'b1;
      tick();
   endtask

   // Pops the oldest expected beat and compares it with what the DUT shows this cycle.
   task automatic checkRetBeat();
      beat_t e;
      `CHK("sb_pending", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         `CHK("ic_ret_valid", ic_ret_valid, !e.to_dc);
         `CHK("dc_ret_valid", dc_ret_valid, e.to_dc);
         `CHK("ic_ret_last", ic_ret_last, e.last && !e.to_dc);
         `CHK("dc_ret_last", dc_ret_last, e.last && e.to_dc);
         `CHK("ret_data", ret_data, e.data);
      end
   endtask

   // Presents one downstream return beat and scoreboards it.
   task automatic driveBeat(input logic to_dc, input logic [31:0] data, input logic last);
      beat_t e;
      mem_ret_valid = 1'b1;
      mem_ret_data  = data;
      mem_ret_last  = last;
      e.to_dc = to_dc;
      e.data  = data;
      e.last  = last;
      sb.push_back(e);
      #1;
      checkRetBeat();
   endtask

   // Called in the R_IDLE cycle in which the grant is expected; returns in the following R_IDLE cycle.
   task automatic serveRead(input logic to_dc, input logic [2:0] typ, input logic [31:0] addr,
                            input int nbeats, input int rdy_delay, input logic expect_wr_busy,
                            input logic [31:0] data_base);
      tick();
      `CHK("mem_rd_req_issue", mem_rd_req, 1'b1);
      `CHK("mem_rd_addr", mem_rd_addr, addr);
      `CHK("mem_rd_type", mem_rd_type, typ);
      if (expect_wr_busy)
         `CHK("mem_wr_req_overlap", mem_wr_req, 1'b1);
      for (int i = 0; i < rdy_delay; i++) begin
         `CHK("rd_rdy_early", {ic_rd_rdy, dc_rd_rdy}, 2'b00);
         tick();
      end
      mem_rd_rdy = 1'b1;
      #1;
      `CHK("ic_rd_rdy", ic_rd_rdy, !to_dc);
      `CHK("dc_rd_rdy", dc_rd_rdy, to_dc);
      tick();
      mem_rd_rdy = 1'b0;
      if (to_dc) dc_rd_req = 1'b0;
      else       ic_rd_req = 1'b0;
      #1;
      `CHK("mem_rd_req_drop", mem_rd_req, 1'b0);
      `CHK("rd_rdy_after", {ic_rd_rdy, dc_rd_rdy}, 2'b00);
      for (int i = 0; i < nbeats; i++) begin
         driveBeat(to_dc, 32'(data_base + 32'(i)), i == nbeats - 1);
         tick();
      end
      mem_ret_valid = 1'b0;
      mem_ret_last  = 1'b0;
      mem_ret_data  = 32'h0;
   endtask

   // Presents a full-line D-cache write-back request.
   task automatic startWrite(input logic [31:0] addr);
      dc_wr_req   = 1'b1;
      dc_wr_type  = 3'b100;
      dc_wr_addr  = addr;
      dc_wr_wstrb = 4'hF;
      dc_wr_data  = WR_LINE;
   endtask

   // Watchdog that stops a hung simulation.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed sequence covering the specification's test list.
   initial begin
      resetDut();

      applyStimulus(1'b1, 3'b100, 32'h0000_1040, 1'b0, 3'b000, 32'h0);
      #1;
      checkMatch("t1_no_req_same_cycle", mem_rd_req === 1'b0);
      serveRead(1'b0, 3'b100, 32'h0000_1040, 4, 2, 1'b0, 32'h1111_0000);
      checkMatch("t1_sb_drained", sb.size() == 0);

      resetDut();
      applyStimulus(1'b1, 3'b100, 32'h0000_2000, 1'b1, 3'b100, 32'h0000_3000);
      serveRead(1'b1, 3'b100, 32'h0000_3000, 4, 0, 1'b0, 32'h2222_0000);
      serveRead(1'b0, 3'b100, 32'h0000_2000, 4, 1, 1'b0, 32'h3333_0000);
      applyStimulus(1'b1, 3'b010, 32'h0000_2100, 1'b1, 3'b010, 32'h0000_3100);
      serveRead(1'b1, 3'b010, 32'h0000_3100, 1, 0, 1'b0, 32'h4444_0000);
      serveRead(1'b0, 3'b010, 32'h0000_2100, 1, 0, 1'b0, 32'h4444_1000);

      startWrite(32'h1000_0020);
      applyStimulus(1'b0, 3'b000, 32'h0, 1'b1, 3'b010, 32'h1000_002C);
      #1;
      checkMatch("t3_wr_rdy_idle", dc_wr_rdy === 1'b1);
      tick();
      dc_wr_req = 1'b0;
      checkMatch("t3_mem_wr_req", mem_wr_req === 1'b1);
      checkMatch("t3_mem_wr_addr", mem_wr_addr === 32'h1000_0020);
      checkMatch("t3_mem_wr_data", mem_wr_data === WR_LINE);
      `CHK("t3_mem_wr_wstrb", mem_wr_wstrb, 4'hF);
      `CHK("t3_mem_wr_type", mem_wr_type, 3'b100);
      for (int i = 0; i < 5; i++) begin
         checkMatch("t3_rd_blocked", mem_rd_req === 1'b0);
         checkMatch("t3_wr_rdy_busy", dc_wr_rdy === 1'b0);
         checkMatch("t3_wr_req_held", mem_wr_req === 1'b1);
         tick();
      end
      mem_wr_rdy = 1'b1;
      #1;
      checkMatch("t3_rd_blocked_at_wr_rdy", mem_rd_req === 1'b0);
      tick();
      mem_wr_rdy = 1'b0;
      checkMatch("t3_wr_req_drop", mem_wr_req === 1'b0);
      checkMatch("t3_wr_rdy_back", dc_wr_rdy === 1'b1);
      checkMatch("t3_rd_not_yet", mem_rd_req === 1'b0);
      serveRead(1'b1, 3'b010, 32'h1000_002C, 1, 0, 1'b0, 32'h5555_0000);

      startWrite(32'h1000_0020);
      applyStimulus(1'b0, 3'b000, 32'h0, 1'b1, 3'b100, 32'h1000_0030);
      #1;
      checkMatch("t4_wr_rdy_idle", dc_wr_rdy === 1'b1);
      serveRead(1'b1, 3'b100, 32'h1000_0030, 4, 1, 1'b1, 32'h6666_0000);
      dc_wr_req = 1'b0;
      checkMatch("t4_wr_still_busy", mem_wr_req === 1'b1);
      checkMatch("t4_wr_rdy_low", dc_wr_rdy === 1'b0);
      mem_wr_rdy = 1'b1;
      tick();
      mem_wr_rdy = 1'b0;
      checkMatch("t4_wr_done", {mem_wr_req, dc_wr_rdy} === 2'b01);

      applyStimulus(1'b1, 3'b010, 32'h0000_2004, 1'b0, 3'b000, 32'h0);
      serveRead(1'b0, 3'b010, 32'h0000_2004, 1, 0, 1'b0, 32'h7777_0000);
      checkMatch("t5_idle_after_word", mem_rd_req === 1'b0);
      applyStimulus(1'b1, 3'b010, 32'h0000_2008, 1'b0, 3'b000, 32'h0);
      serveRead(1'b0, 3'b010, 32'h0000_2008, 1, 0, 1'b0, 32'h7777_1000);

      applyStimulus(1'b1, 3'b100, 32'h0000_4000, 1'b0, 3'b000, 32'h0);
      tick();
      mem_rd_rdy = 1'b1;
      #1;
      checkMatch("t6_ic_rd_rdy", ic_rd_rdy === 1'b1);
      tick();
      mem_rd_rdy = 1'b0;
      ic_rd_req  = 1'b0;
      driveBeat(1'b0, 32'h8888_0000, 1'b0);
      tick();
      mem_ret_valid = 1'b1;
      mem_ret_data  = 32'h8888_0001;
      mem_ret_last  = 1'b0;
      rst_n = 1'b0;
      #1;
      checkIdleOutputs("t6_mid_reset");
      mem_ret_valid = 1'b0;
      mem_ret_data  = 32'h0;
      tick();
      rst_n = 1'b1;
      tick();
      applyStimulus(1'b0, 3'b000, 32'h0, 1'b1, 3'b010, 32'h0000_3008);
      serveRead(1'b1, 3'b010, 32'h0000_3008, 1, 0, 1'b0, 32'h9999_0000);
      checkMatch("end_sb_drained", sb.size() == 0);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
